// File: rtl/fde_pkg.sv
// fde_pkg: shared FSM state encoding, default widths and bubble NOP for the FDE pipeline controller
package fde_pkg;
    typedef enum logic [1:0] {RUN = 2'd0, STALL_EX = 2'd1, FLUSH = 2'd2, HALT = 2'd3} state_t;
    localparam int REG_W_DEF = 5;
    localparam int CNT_W_DEF = 16;
    localparam logic [31:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/fde_hazard_unit.sv
// fde_hazard_unit: combinational load-use hazard detector between decode and execute
module fde_hazard_unit import fde_pkg::*; #(
    parameter int REG_W = REG_W_DEF
) (
    input  logic             v_id,
    input  logic             v_ex,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    output logic             lu
);
    assign lu = v_id && v_ex && ex_is_load && (ex_rd != '0) && (ex_rd == id_rs1 || ex_rd == id_rs2);
endmodule

// File: rtl/fde_pipe_ctrl.sv
// fde_pipe_ctrl: fetch/decode/execute stall, flush and halt controller; FDE_STALL_CNT_EN builds the stall counter
module fde_pipe_ctrl import fde_pkg::*; #(
    parameter int REG_W = REG_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             if_valid,
    output logic             if_ready,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             id_ex_bubble,
    output logic             flush,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_is_load,
    input  logic             ex_busy,
    input  logic             br_taken,
    input  logic             halt_req,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);
    state_t state, state_nxt;
    logic v_id, v_ex, v_id_nxt, v_ex_nxt, lu, br;
    logic rdy, ife, ide, bub, fl, hlt;
    fde_hazard_unit #(.REG_W(REG_W)) u_hazard (
        .v_id(v_id), .v_ex(v_ex), .ex_is_load(ex_is_load),
        .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .lu(lu)
    );
    assign br = br_taken && v_ex;
    // STALL_EX shares RUN's priority logic so the first non-busy cycle already acts as RUN
    always_comb begin
        rdy = 1'b0;
        ife = 1'b0;
        ide = 1'b0;
        bub = 1'b0;
        fl = 1'b0;
        hlt = 1'b0;
        state_nxt = state;
        v_id_nxt = v_id;
        v_ex_nxt = v_ex;
        case (state)
            RUN, STALL_EX: begin
                if (ex_busy) begin
                    state_nxt = STALL_EX;
                end else if (br) begin
                    fl = 1'b1;
                    v_id_nxt = 1'b0;
                    v_ex_nxt = 1'b0;
                    state_nxt = FLUSH;
                end else if (lu) begin
                    ide = 1'b1;
                    bub = 1'b1;
                    v_ex_nxt = 1'b0;
                    state_nxt = RUN;
                end else begin
                    ide = 1'b1;
                    rdy = !halt_req;
                    ife = rdy && if_valid;
                    v_ex_nxt = v_id;
                    v_id_nxt = ife;
                    state_nxt = (halt_req && !v_id) ? HALT : RUN;
                end
            end
            FLUSH: state_nxt = RUN;
            HALT: begin
                hlt = 1'b1;
                state_nxt = halt_req ? HALT : RUN;
            end
            default: state_nxt = RUN;
        endcase
    end
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= RUN;
            v_id <= 1'b0;
            v_ex <= 1'b0;
        end else begin
            state <= state_nxt;
            v_id <= v_id_nxt;
            v_ex <= v_ex_nxt;
        end
    end
    assign {if_ready, if_id_en, id_ex_en, id_ex_bubble, flush, halted} =
        resetn ? {rdy, ife, ide, bub, fl, hlt} : 6'b0;
`ifdef FDE_STALL_CNT_EN
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clock) begin
        if (!resetn) cnt <= '0;
        else if ((state == STALL_EX || lu) && cnt != '1) cnt <= cnt + CNT_W'(1);
    end
    assign stall_cnt = resetn ? cnt : '0;
`else
    assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_fde_pipe_ctrl.sv
// tb_fde_pipe_ctrl: directed self-checking bench for fde_pipe_ctrl
module tb_fde_pipe_ctrl;
`ifdef FDE_STALL_CNT_EN
    localparam int EN = 1;
`else
    localparam int EN = 0;
`endif
    logic clock, resetn, if_valid, ex_is_load, ex_busy, br_taken, halt_req;
    logic if_ready, if_id_en, id_ex_en, id_ex_bubble, flush, halted;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic [15:0] stall_cnt;
    logic [5:0] o;
    int n_cmp = 0;
    int n_err = 0;
    assign o = {if_ready, if_id_en, id_ex_en, id_ex_bubble, flush, halted};

    fde_pipe_ctrl dut (
        .clock(clock), .resetn(resetn), .if_valid(if_valid), .if_ready(if_ready),
        .if_id_en(if_id_en), .id_ex_en(id_ex_en), .id_ex_bubble(id_ex_bubble), .flush(flush),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
        .ex_busy(ex_busy), .br_taken(br_taken), .halt_req(halt_req), .halted(halted),
        .stall_cnt(stall_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_in();
        if_valid = 0; ex_is_load = 0; ex_busy = 0; br_taken = 0; halt_req = 0;
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    endtask

    task automatic reset_fill();
        clear_in();
        resetn = 0;
        tick(); tick();
        resetn = 1;
        if_valid = 1;
        tick(); tick();
    endtask

    task automatic test_reset();
        clear_in();
        resetn = 0;
        if_valid = 1;
        #1;
        n_cmp++; if (o !== 6'b0) begin n_err++; $display("FAIL reset_pre: got %b exp %b", o, 6'b0); end
        tick();
        n_cmp++; if (o !== 6'b0) begin n_err++; $display("FAIL reset_cyc1: got %b exp %b", o, 6'b0); end
        n_cmp++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL reset_cnt: got %0d exp 0", stall_cnt); end
        tick();
        n_cmp++; if (o !== 6'b0) begin n_err++; $display("FAIL reset_cyc2: got %b exp %b", o, 6'b0); end
        resetn = 1;
        #1;
        n_cmp++; if (o !== 6'b111000) begin n_err++; $display("FAIL reset_release: got %b exp %b", o, 6'b111000); end
    endtask

    task automatic test_load_use();
        reset_fill();
        ex_is_load = 1; ex_rd = 3; id_rs1 = 1; id_rs2 = 3;
        #1;
        n_cmp++; if (o !== 6'b001100) begin n_err++; $display("FAIL lu_bubble: got %b exp %b", o, 6'b001100); end
        tick();
        n_cmp++; if (o !== 6'b111000) begin n_err++; $display("FAIL lu_after: got %b exp %b", o, 6'b111000); end
        n_cmp++; if ({dut.v_id, dut.v_ex} !== 2'b10) begin n_err++; $display("FAIL lu_valid: got %b exp 10", {dut.v_id, dut.v_ex}); end
        n_cmp++; if (stall_cnt !== 16'(EN)) begin n_err++; $display("FAIL lu_cnt: got %0d exp %0d", stall_cnt, EN); end
    endtask

    task automatic test_rd_zero();
        reset_fill();
        ex_is_load = 1; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
        #1;
        n_cmp++; if (o !== 6'b111000) begin n_err++; $display("FAIL rd_zero: got %b exp %b", o, 6'b111000); end
        ex_rd = 5; id_rs1 = 5; id_rs2 = 2;
        #1;
        n_cmp++; if (o !== 6'b001100) begin n_err++; $display("FAIL lu_rs1: got %b exp %b", o, 6'b001100); end
    endtask

    task automatic test_branch();
        clear_in();
        resetn = 0;
        tick();
        resetn = 1;
        if_valid = 1; br_taken = 1;
        #1;
        n_cmp++; if (o !== 6'b111000) begin n_err++; $display("FAIL br_unqualified: got %b exp %b", o, 6'b111000); end
        reset_fill();
        br_taken = 1;
        #1;
        n_cmp++; if (o !== 6'b000010) begin n_err++; $display("FAIL br_flush: got %b exp %b", o, 6'b000010); end
        tick();
        br_taken = 0;
        #1;
        n_cmp++; if (o !== 6'b000000) begin n_err++; $display("FAIL br_slot: got %b exp %b", o, 6'b000000); end
        n_cmp++; if ({dut.v_id, dut.v_ex} !== 2'b00) begin n_err++; $display("FAIL br_valid: got %b exp 00", {dut.v_id, dut.v_ex}); end
        tick();
        n_cmp++; if (o !== 6'b111000) begin n_err++; $display("FAIL br_resume: got %b exp %b", o, 6'b111000); end
    endtask

    task automatic test_multicycle();
        reset_fill();
        ex_busy = 1; br_taken = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++; if (o !== 6'b000000) begin n_err++; $display("FAIL busy_cyc%0d: got %b exp %b", i, o, 6'b000000); end
            tick();
        end
        ex_busy = 0;
        #1;
        n_cmp++; if (o !== 6'b000010) begin n_err++; $display("FAIL busy_release_flush: got %b exp %b", o, 6'b000010); end
        tick();
        br_taken = 0;
        #1;
        n_cmp++; if (stall_cnt !== 16'(5 * EN)) begin n_err++; $display("FAIL busy_cnt: got %0d exp %0d", stall_cnt, 5 * EN); end
        n_cmp++; if (o !== 6'b000000) begin n_err++; $display("FAIL busy_slot: got %b exp %b", o, 6'b000000); end
    endtask

    task automatic test_halt();
        reset_fill();
        halt_req = 1;
        #1;
        n_cmp++; if (o !== 6'b001000) begin n_err++; $display("FAIL halt_drain0: got %b exp %b", o, 6'b001000); end
        tick();
        n_cmp++; if (o !== 6'b001000) begin n_err++; $display("FAIL halt_drain1: got %b exp %b", o, 6'b001000); end
        tick();
        n_cmp++; if (o !== 6'b000001) begin n_err++; $display("FAIL halt_entered: got %b exp %b", o, 6'b000001); end
        tick();
        n_cmp++; if (o !== 6'b000001) begin n_err++; $display("FAIL halt_hold: got %b exp %b", o, 6'b000001); end
        halt_req = 0;
        tick();
        n_cmp++; if (o !== 6'b111000) begin n_err++; $display("FAIL halt_exit: got %b exp %b", o, 6'b111000); end
        tick();
        n_cmp++; if (dut.v_id !== 1'b1) begin n_err++; $display("FAIL halt_fetch: got %b exp 1", dut.v_id); end
    endtask

    task automatic test_halt_abort();
        reset_fill();
        halt_req = 1;
        tick();
        halt_req = 0;
        #1;
        n_cmp++; if (o !== 6'b111000) begin n_err++; $display("FAIL halt_abort: got %b exp %b", o, 6'b111000); end
    endtask

    task automatic test_reset_mid();
        reset_fill();
        ex_busy = 1;
        tick();
        resetn = 0;
        #1;
        n_cmp++; if (o !== 6'b000000) begin n_err++; $display("FAIL rst_mid_low: got %b exp %b", o, 6'b000000); end
        tick();
        resetn = 1; ex_busy = 0;
        #1;
        n_cmp++; if (o !== 6'b111000) begin n_err++; $display("FAIL rst_mid_release: got %b exp %b", o, 6'b111000); end
        n_cmp++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL rst_mid_cnt: got %0d exp 0", stall_cnt); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_rd_zero();
        test_branch();
        test_multicycle();
        test_halt();
        test_halt_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
